// File: rtl/neuron_cfg_tx.sv
// Serialises one neuron configuration command into a paced byte packet:
// opcode, address (2 bytes), and 4 value bytes unless opcode[7] marks a short packet.
module neuron_cfg_tx #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [9:0]  cmd_addr,
  input  logic [31:0] cmd_value,
  output logic [7:0]  data,
  output logic        load_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);
  localparam bit         NoGap   = (GAP_CYCLES == 0);

  state_e      state_q;
  logic [7:0]  opcode_q;
  logic [9:0]  addr_q;
  logic [31:0] value_q;
  logic [2:0]  byte_idx_q;
  logic [7:0]  gap_cnt_q;

  logic [2:0]  last_idx;
  logic [2:0]  next_idx;
  logic [7:0]  next_byte;

  // Byte 0 is loaded straight from cmd_opcode at accept; later bytes come from the shadow regs.
  always_comb begin
    last_idx = opcode_q[7] ? 3'd2 : 3'd6;
    next_idx = byte_idx_q + 3'd1;
    case (next_idx)
      3'd1:    next_byte = {6'b0, addr_q[9:8]};
      3'd2:    next_byte = addr_q[7:0];
      3'd3:    next_byte = value_q[31:24];
      3'd4:    next_byte = value_q[23:16];
      3'd5:    next_byte = value_q[15:8];
      3'd6:    next_byte = value_q[7:0];
      default: next_byte = 8'h00;
    endcase
  end

  assign cmd_ready = (state_q == StIdle) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      opcode_q   <= 8'h00;
      addr_q     <= 10'h000;
      value_q    <= 32'h0;
      byte_idx_q <= 3'd0;
      gap_cnt_q  <= 8'd0;
      data       <= 8'h00;
      load_data  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            opcode_q   <= cmd_opcode;
            addr_q     <= cmd_addr;
            value_q    <= cmd_value;
            byte_idx_q <= 3'd0;
            data       <= cmd_opcode;
            load_data  <= 1'b1;
            busy       <= 1'b1;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (byte_idx_q == last_idx) begin
            data      <= 8'h00;
            load_data <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= StDone;
          end else if (NoGap) begin
            byte_idx_q <= next_idx;
            data       <= next_byte;
          end else begin
            gap_cnt_q <= 8'd0;
            data      <= 8'h00;
            load_data <= 1'b0;
            state_q   <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            byte_idx_q <= next_idx;
            data       <= next_byte;
            load_data  <= 1'b1;
            state_q    <= StSend;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_cfg_tx.sv
// Bench for neuron_cfg_tx: three instances (gap 0, 1, 2) on shared stimulus, checked every
// cycle against a timing-formula model, plus literal packet/latency checks per scenario.
module tb_neuron_cfg_tx;

  localparam int EvLoad = 0;
  localparam int EvDone = 1;
  localparam int EvAcc  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_value;
  logic        cmd_ready [3];
  logic [7:0]  data      [3];
  logic        load_data [3];
  logic        busy      [3];
  logic        done      [3];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      neuron_cfg_tx #(.GAP_CYCLES(g)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready[g]),
        .cmd_opcode (cmd_opcode),
        .cmd_addr   (cmd_addr),
        .cmd_value  (cmd_value),
        .data       (data[g]),
        .load_data  (load_data[g]),
        .busy       (busy[g]),
        .done       (done[g])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int         inst;
    int         kind;
    int         cyc;
    logic [7:0] val;
  } ev_t;
  ev_t evq[$];

  // Model: per instance, the accepted command and the cycle it was accepted in.
  bit         m_act [3];
  int         m_acc [3];
  int         m_len [3];
  logic [7:0] m_b   [3][7];

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  function automatic int count_ev(input int inst, input int kind);
    int n = 0;
    foreach (evq[j]) if (evq[j].inst == inst && evq[j].kind == kind) n++;
    return n;
  endfunction

  function automatic ev_t nth_ev(input int inst, input int kind, input int n);
    ev_t r;
    int  m = 0;
    bit  found = 1'b0;
    r = '{inst: -1, kind: -1, cyc: -1000, val: 8'h00};
    foreach (evq[j]) begin
      if (!found && evq[j].inst == inst && evq[j].kind == kind) begin
        if (m == n) begin
          r = evq[j];
          found = 1'b1;
        end
        m++;
      end
    end
    return r;
  endfunction

  // Checks one packet: bytes, offsets of each byte and of done relative to its accept.
  task automatic chk_pkt(input string name, input int inst, input int nth_acc,
                         input int first_load, input int len, input int gp, input int done_off,
                         input logic [7:0] exp [7]);
    ev_t a;
    ev_t l;
    ev_t d;
    a = nth_ev(inst, EvAcc, nth_acc);
    for (int n = 0; n < len; n++) begin
      l = nth_ev(inst, EvLoad, first_load + n);
      chk({name, "_byte"}, inst, 32'(l.val), 32'(exp[n]));
      chk({name, "_ofs"}, inst, l.cyc - a.cyc, 1 + n * gp);
    end
    d = nth_ev(inst, EvDone, nth_acc);
    chk({name, "_done_ofs"}, inst, d.cyc - a.cyc, done_off);
  endtask

  // Compare process: every cycle, every instance, against the model.
  initial begin
    int         k;
    int         gp;
    int         last_k;
    bit         idle;
    bit         e_busy;
    bit         e_load;
    bit         e_done;
    bit         e_ready;
    logic [7:0] e_data;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        gp     = i + 1;
        k      = cyc - m_acc[i] - 1;
        last_k = (m_len[i] - 1) * gp;
        idle   = 1'b1;
        e_busy = 1'b0;
        e_load = 1'b0;
        e_done = 1'b0;
        e_data = 8'h00;
        if (m_act[i]) begin
          if (k <= last_k) begin
            idle   = 1'b0;
            e_busy = 1'b1;
            if (k % gp == 0) begin
              e_load = 1'b1;
              e_data = m_b[i][k/gp];
            end
          end else if (k == last_k + 1) begin
            idle   = 1'b0;
            e_done = 1'b1;
          end
        end
        e_ready = !rst && idle;
        if (chk_en) begin
          chk("data", i, 32'(data[i]), 32'(e_data));
          chk("load_data", i, 32'(load_data[i]), 32'(e_load));
          chk("busy", i, 32'(busy[i]), 32'(e_busy));
          chk("done", i, 32'(done[i]), 32'(e_done));
          chk("cmd_ready", i, 32'(cmd_ready[i]), 32'(e_ready));
          if (load_data[i]) evq.push_back('{inst: i, kind: EvLoad, cyc: cyc, val: data[i]});
          if (done[i]) evq.push_back('{inst: i, kind: EvDone, cyc: cyc, val: 8'h00});
          if (cmd_ready[i] && cmd_valid)
            evq.push_back('{inst: i, kind: EvAcc, cyc: cyc, val: 8'h00});
        end
        if (rst) begin
          m_act[i] = 1'b0;
        end else if (e_ready && cmd_valid) begin
          m_act[i]   = 1'b1;
          m_acc[i]   = cyc;
          m_len[i]   = cmd_opcode[7] ? 3 : 7;
          m_b[i][0]  = cmd_opcode;
          m_b[i][1]  = {6'b0, cmd_addr[9:8]};
          m_b[i][2]  = cmd_addr[7:0];
          m_b[i][3]  = cmd_value[31:24];
          m_b[i][4]  = cmd_value[23:16];
          m_b[i][5]  = cmd_value[15:8];
          m_b[i][6]  = cmd_value[7:0];
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [9:0] ad, input logic [31:0] val);
    cmd_opcode = op;
    cmd_addr   = ad;
    cmd_value  = val;
    cmd_valid  = 1'b1;
    step(1);
    cmd_valid  = 1'b0;
  endtask

  initial begin
    ev_t e0;
    ev_t e1;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = 8'h00;
    cmd_addr   = 10'h000;
    cmd_value  = 32'h0;

    // T1: reset values, ready right after release
    step(3);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_load", i, 32'(load_data[i]), 0);
      chk("t1_data", i, 32'(data[i]), 0);
      chk("t1_busy", i, 32'(busy[i]), 0);
      chk("t1_done", i, 32'(done[i]), 0);
      chk("t1_ready_in_rst", i, 32'(cmd_ready[i]), 0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk("t1_ready", i, 32'(cmd_ready[i]), 1);

    // T2: long packet, gap 1
    evq.delete();
    issue(8'h02, 10'h2A5, 32'hDEADBEEF);
    step(20);
    chk_pkt("t2", 1, 0, 0, 7, 2, 14, '{8'h02, 8'h02, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    chk("t2_nload", 1, count_ev(1, EvLoad), 7);
    chk("t2_ndone", 1, count_ev(1, EvDone), 1);

    // T3: short packet, gap 0
    evq.delete();
    issue(8'h81, 10'h003, 32'h12345678);
    step(10);
    chk_pkt("t3", 0, 0, 0, 3, 1, 4, '{8'h81, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00});
    chk("t3_nload", 0, count_ev(0, EvLoad), 3);

    // T4: valid held with a changed command while busy
    evq.delete();
    cmd_opcode = 8'h05;
    cmd_addr   = 10'h1FF;
    cmd_value  = 32'hCAFEF00D;
    cmd_valid  = 1'b1;
    step(1);
    cmd_opcode = 8'h06;
    cmd_addr   = 10'h155;
    cmd_value  = 32'h0;
    step(10);
    cmd_valid  = 1'b0;
    step(25);
    chk("t4_nacc", 1, count_ev(1, EvAcc), 1);
    chk("t4_nacc", 2, count_ev(2, EvAcc), 1);
    chk("t4_nacc", 0, count_ev(0, EvAcc), 2);
    chk_pkt("t4", 1, 0, 0, 7, 2, 14, '{8'h05, 8'h01, 8'hFF, 8'hCA, 8'hFE, 8'hF0, 8'h0D});
    chk_pkt("t4b", 0, 1, 7, 7, 1, 8, '{8'h06, 8'h01, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00});

    // T5: reset after B3 of the gap-1 instance
    evq.delete();
    issue(8'h02, 10'h2A5, 32'hDEADBEEF);
    step(7);
    rst = 1'b1;
    step(1);
    chk("t5_load_after_rst", 1, 32'(load_data[1]), 0);
    chk("t5_busy_after_rst", 1, 32'(busy[1]), 0);
    chk("t5_done_after_rst", 1, 32'(done[1]), 0);
    rst = 1'b0;
    step(5);
    chk("t5_nload", 1, count_ev(1, EvLoad), 4);
    chk("t5_ndone", 1, count_ev(1, EvDone), 0);
    chk("t5_nload", 2, count_ev(2, EvLoad), 3);
    e0 = nth_ev(1, EvLoad, 3);
    chk("t5_b3", 1, 32'(e0.val), 32'hDE);
    evq.delete();
    issue(8'h03, 10'h0F0, 32'h01020304);
    step(20);
    chk_pkt("t5", 1, 0, 0, 7, 2, 14, '{8'h03, 8'h00, 8'hF0, 8'h01, 8'h02, 8'h03, 8'h04});

    // T6: back-to-back long packets, gap 2
    evq.delete();
    cmd_opcode = 8'h02;
    cmd_addr   = 10'h2A5;
    cmd_value  = 32'hDEADBEEF;
    cmd_valid  = 1'b1;
    for (int c = 0; c < 80 && count_ev(2, EvAcc) < 2; c++) step(1);
    cmd_valid = 1'b0;
    chk("t6_nacc", 2, count_ev(2, EvAcc), 2);
    step(25);
    chk("t6_nload", 2, count_ev(2, EvLoad), 14);
    chk("t6_ndone", 2, count_ev(2, EvDone), 2);
    e0 = nth_ev(2, EvDone, 0);
    e1 = nth_ev(2, EvLoad, 7);
    chk("t6_b0_after_done", 2, e1.cyc - e0.cyc, 2);
    e0 = nth_ev(2, EvAcc, 0);
    e1 = nth_ev(2, EvAcc, 1);
    chk("t6_acc_spacing", 2, e1.cyc - e0.cyc, 21);
    chk_pkt("t6", 2, 1, 7, 7, 3, 20, '{8'h02, 8'h02, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
